// File: rtl/mac_pipe_pkg.sv
// Shared widths, saturation bounds and the pipeline stage record for mac_pipe.
// Stage payloads are carried sign/zero-extended to P_MAX bits so one record type fits every BITS.
package mac_pipe_pkg;

  localparam int P_MAX = 64;

  typedef logic signed [P_MAX-1:0] wide_t;

  typedef struct packed {
    logic  valid;
    logic  acc;
    wide_t p;
  } stage_t;

  function automatic int p_width(input int bits);
    return 2 * bits + 1;
  endfunction

  function automatic int s_width(input int bits);
    return 2 * bits + 2;
  endfunction

  function automatic wide_t sat_umax(input int w);
    wide_t one;
    one = 1;
    return (one <<< w) - one;
  endfunction

  function automatic wide_t sat_smax(input int w);
    wide_t one;
    one = 1;
    return (one <<< (w - 1)) - one;
  endfunction

  function automatic wide_t sat_smin(input int w);
    wide_t one;
    one = 1;
    return -(one <<< (w - 1));
  endfunction

  // Representable range of a w-bit result under the selected signedness.
  function automatic wide_t sat_hi(input int w, input bit sgn);
    return sgn ? sat_smax(w) : sat_umax(w);
  endfunction

  function automatic wide_t sat_lo(input int w, input bit sgn);
    return sgn ? sat_smin(w) : '0;
  endfunction

endpackage

// File: rtl/mac_pipe_sat.sv
// Final-stage adder: p plus optional previous result, range check, wrap or clamp to W bits.
// Combinational; MAC_SAT_EN selects clamping on overflow, otherwise the result wraps.
module mac_pipe_sat
  import mac_pipe_pkg::*;
#(
  parameter int W      = 8,
  parameter int SIGNED = 0
) (
  input  wide_t          p,
  input  logic           acc,
  input  logic [W-1:0]   o_prev,
  output logic [W-1:0]   o_next,
  output logic           ovf
);

  localparam bit    SGN = (SIGNED != 0);
  localparam wide_t HI  = sat_hi(W, SGN);
  localparam wide_t LO  = sat_lo(W, SGN);

  wide_t o_wide;
  wide_t s;

  always_comb begin
    o_wide = {{(P_MAX-W){SGN & o_prev[W-1]}}, o_prev};
    s      = p + (acc ? o_wide : wide_t'(0));
    ovf    = (s > HI) || (s < LO);
`ifdef MAC_SAT_EN
    if (s > HI)
      o_next = HI[W-1:0];
    else if (s < LO)
      o_next = LO[W-1:0];
    else
      o_next = s[W-1:0];
`else
    o_next = s[W-1:0];
`endif
  end

endmodule

// File: rtl/mac_pipe.sv
// Pipelined a*b+ci with optional accumulation into o; MAC_SAT_EN enables saturation on overflow.
// Latency DEPTH-1 edges after accept; one global enable stalls every stage while o is held unconsumed.
module mac_pipe
  import mac_pipe_pkg::*;
#(
  parameter int BITS   = 4,
  parameter int DEPTH  = 4,
  parameter int SIGNED = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BITS-1:0]   a,
  input  logic [BITS-1:0]   b,
  input  logic [2*BITS-1:0] ci,
  input  logic              acc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*BITS-1:0] o,
  output logic              ovf
);

  localparam int W   = 2 * BITS;
  localparam int PW  = p_width(BITS);
  localparam bit SGN = (SIGNED != 0);

  logic          advance;
  stage_t        pipe [DEPTH-1];
  logic [PW-1:0] a_x, b_x, ci_x, p_n;
  wide_t         p_wide;
  logic [W-1:0]  o_next;
  logic          ovf_next;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance && rst;

  // Product and addend are exact in PW bits, then widened for the stage record.
  always_comb begin
    a_x    = {{(PW-BITS){SGN & a[BITS-1]}}, a};
    b_x    = {{(PW-BITS){SGN & b[BITS-1]}}, b};
    ci_x   = {{(PW-W){SGN & ci[W-1]}}, ci};
    p_n    = a_x * b_x + ci_x;
    p_wide = {{(P_MAX-PW){SGN & p_n[PW-1]}}, p_n};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH-1; i++)
        pipe[i] <= '0;
      out_valid <= 1'b0;
      o         <= '0;
      ovf       <= 1'b0;
    end else if (advance) begin
      pipe[0] <= '{valid: in_valid && in_ready, acc: acc, p: p_wide};
      for (int i = 1; i < DEPTH-1; i++)
        pipe[i] <= pipe[i-1];
      out_valid <= pipe[DEPTH-2].valid;
      // Bubbles leave o untouched so chained acc beats survive idle gaps.
      if (pipe[DEPTH-2].valid) begin
        o   <= o_next;
        ovf <= ovf_next;
      end
    end
  end

  mac_pipe_sat #(
    .W      (W),
    .SIGNED (SIGNED)
  ) u_sat (
    .p      (pipe[DEPTH-2].p),
    .acc    (pipe[DEPTH-2].acc),
    .o_prev (o),
    .o_next (o_next),
    .ovf    (ovf_next)
  );

endmodule

// File: tb/tb_mac_pipe.sv
// Scoreboard bench: unsigned and signed mac_pipe instances share one stimulus stream.
module tb_mac_pipe;

  localparam int DEPTH = 4;
`ifdef MAC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    logic [7:0] o;
    bit         ovf;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [3:0] a, b;
  logic [7:0] ci;
  logic       acc;
  logic       out_ready;
  logic       in_ready0, out_valid0, ovf0;
  logic       in_ready1, out_valid1, ovf1;
  logic [7:0] o0, o1;

  int     checks = 0;
  int     errors = 0;
  bit     rand_rdy = 0;
  longint prev [2];
  exp_t   q0 [$];
  exp_t   q1 [$];
  exp_t   e0, e1;
  int     lat, k, run;

  mac_pipe #(.BITS(4), .DEPTH(DEPTH), .SIGNED(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .a(a), .b(b), .ci(ci), .acc(acc),
    .out_valid(out_valid0), .out_ready(out_ready), .o(o0), .ovf(ovf0)
  );

  mac_pipe #(.BITS(4), .DEPTH(DEPTH), .SIGNED(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .a(a), .b(b), .ci(ci), .acc(acc),
    .out_valid(out_valid1), .out_ready(out_ready), .o(o1), .ovf(ovf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic longint val4(input bit sg, input logic [3:0] x);
    if (sg) return longint'($signed(x));
    return longint'(x);
  endfunction

  function automatic longint val8(input bit sg, input logic [7:0] x);
    if (sg) return longint'($signed(x));
    return longint'(x);
  endfunction

  // Reference: exact integer arithmetic, then clamp or keep the low byte.
  task automatic push(input logic [3:0] ta, input logic [3:0] tb, input logic [7:0] tci, input bit tacc);
    for (int d = 0; d < 2; d++) begin
      longint s, lo, hi, r;
      exp_t   e;
      bit     sg;
      sg = (d == 1);
      s  = val4(sg, ta) * val4(sg, tb) + val8(sg, tci) + (tacc ? prev[d] : 64'sd0);
      lo = sg ? -128 : 0;
      hi = sg ? 127 : 255;
      e.ovf = (s < lo) || (s > hi);
      r = (SAT && e.ovf) ? ((s < lo) ? lo : hi) : s;
      e.o = r[7:0];
      prev[d] = val8(sg, e.o);
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
  endtask

  task automatic send(input logic [3:0] ta, input logic [3:0] tb, input logic [7:0] tci, input bit tacc);
    int n;
    bit done;
    n = 0;
    done = 0;
    a = ta; b = tb; ci = tci; acc = tacc; in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (in_ready0) begin
        push(ta, tb, tci, tacc);
        done = 1;
      end else if (++n > 200) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout in_ready=0 required=1");
        done = 1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string nm, input logic [7:0] x0, input bit v0,
                          input logic [7:0] x1, input bit v1, output int l);
    l = 0;
    do begin
      @(negedge clk);
      l++;
    end while (!out_valid0 && l < 30);
    if (!out_valid0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout out_valid=0 required=1", nm);
    end else begin
      chk({nm, "_o_u"}, o0, x0);
      chk({nm, "_ovf_u"}, ovf0, v0);
      chk({nm, "_o_s"}, o1, x1);
      chk({nm, "_ovf_s"}, ovf1, v1);
    end
    @(posedge clk); #1;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_drain"}, q0.size() + q1.size(), 0);
  endtask

  always @(posedge clk) begin
    #1;
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
  end

  always @(negedge clk) begin
    if (rst && out_ready && out_valid0) begin
      if (q0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_u_unexpected o=%0d required=none", o0);
      end else begin
        e0 = q0.pop_front();
        chk("sb_u_o", o0, e0.o);
        chk("sb_u_ovf", ovf0, e0.ovf);
      end
    end
  end

  always @(negedge clk) begin
    if (rst && out_ready && out_valid1) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_s_unexpected o=%0d required=none", o1);
      end else begin
        e1 = q1.pop_front();
        chk("sb_s_o", o1, e1.o);
        chk("sb_s_ovf", ovf1, e1.ovf);
      end
    end
  end

  initial begin
    rst = 1'b0; in_valid = 1'b0; a = '0; b = '0; ci = '0; acc = 1'b0; out_ready = 1'b1;
    prev[0] = 0; prev[1] = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready0, 0);
    chk("rst_out_valid", out_valid0, 0);
    chk("rst_o", o0, 0);
    chk("rst_ovf", ovf0, 0);
    chk("rst_out_valid_s", out_valid1, 0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Single beat and its latency.
    send(4'd3, 4'd5, 8'd10, 1'b0);
    wait_out("t1", 8'd25, 1'b0, 8'd25, 1'b0, lat);
    chk("t1_latency", lat, DEPTH);
    drain("t1");

    // Back-to-back beats must emerge as one unbroken run.
    fork
      for (int i = 0; i < 8; i++) send(4'(i), 4'd2, 8'd0, 1'b0);
      begin
        k = 0;
        do begin @(negedge clk); k++; end while (!out_valid0 && k < 30);
        run = 0;
        while (out_valid0 && run < 20) begin run++; @(negedge clk); end
        chk("t2_run_len", run, 8);
      end
    join
    @(posedge clk); #1;
    drain("t2");

    // Fill under backpressure, hold three cycles, then release.
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send(4'(i), 4'd1, 8'd0, 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk("t3_in_ready", in_ready0, 0);
      chk("t3_in_ready_s", in_ready1, 0);
      chk("t3_out_valid", out_valid0, 1);
      chk("t3_o_hold", o0, 1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    drain("t3");

    // Accumulation chain.
    send(4'd2, 4'd3, 8'd0, 1'b0);
    wait_out("t4a", 8'd6, 1'b0, 8'd6, 1'b0, lat);
    send(4'd4, 4'd4, 8'd1, 1'b1);
    wait_out("t4b", 8'd23, 1'b0, 8'd23, 1'b0, lat);
    send(4'd1, 4'd1, 8'd0, 1'b1);
    wait_out("t4c", 8'd24, 1'b0, 8'd24, 1'b0, lat);
    drain("t4");

    // Overflow corners.
    send(4'hF, 4'hF, 8'hFF, 1'b0);
    wait_out("t5u", SAT ? 8'd255 : 8'd224, 1'b1, 8'd0, 1'b0, lat);
    send(4'h8, 4'h8, 8'h7F, 1'b0);
    wait_out("t5s", 8'd191, 1'b0, SAT ? 8'h7F : 8'hBF, 1'b1, lat);
    drain("t5");

    // Randomized traffic with random backpressure and idle gaps.
    rand_rdy = 1;
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      send(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end
    rand_rdy = 0;
    out_ready = 1'b1;
    drain("rand");

    // Reset with three beats in flight, then accumulate from zero.
    send(4'd5, 4'd5, 8'd9, 1'b0);
    send(4'd6, 4'd6, 8'd9, 1'b1);
    send(4'd7, 4'd7, 8'd9, 1'b1);
    rst = 1'b0;
    q0.delete();
    q1.delete();
    prev[0] = 0; prev[1] = 0;
    @(negedge clk);
    chk("t6_in_ready_rst", in_ready0, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("t6_out_valid", out_valid0, 0);
    chk("t6_o", o0, 0);
    chk("t6_ovf", ovf0, 0);
    @(posedge clk); #1;
    send(4'd2, 4'd2, 8'd0, 1'b1);
    wait_out("t6", 8'd4, 1'b0, 8'd4, 1'b0, lat);
    drain("t6");
    repeat (6) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
